// File: rtl/rpi_bridge_pkg.sv
// rtl/rpi_bridge_pkg.sv - shared types and constants for the RPi parallel bus bridge
package rpi_bridge_pkg;

    localparam int BUS_AW = 2;
    localparam int BUS_DW = 8;

    localparam logic [BUS_DW-1:0] TIMEOUT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } bridge_state_e;

endpackage

// File: rtl/rpi_bus_bridge_if.sv
// rtl/rpi_bus_bridge_if.sv - RPi pin bus plus wishbone request bundle
// slave: the bridge itself; master: the RPi pins and the UART wishbone slave around it.
interface rpi_bus_bridge_if;
    import rpi_bridge_pkg::*;

    logic              pin_clk;
    logic              pin_cs;
    logic              pin_we;
    logic [BUS_AW-1:0] pin_addr;
    logic [BUS_DW-1:0] pin_data_in;
    logic [BUS_DW-1:0] pin_data_out;
    logic              pin_ack;

    logic [BUS_AW-1:0] wb_addr;
    logic [BUS_DW-1:0] wb_data_out;
    logic [BUS_DW-1:0] wb_data_in;
    logic              wb_we;
    logic              wb_stb;
    logic              wb_cyc;
    logic              wb_ack;

    modport slave (
        input  pin_clk, pin_cs, pin_we, pin_addr, pin_data_in, wb_data_in, wb_ack,
        output pin_data_out, pin_ack, wb_addr, wb_data_out, wb_we, wb_stb, wb_cyc
    );

    modport master (
        output pin_clk, pin_cs, pin_we, pin_addr, pin_data_in, wb_data_in, wb_ack,
        input  pin_data_out, pin_ack, wb_addr, wb_data_out, wb_we, wb_stb, wb_cyc
    );

endinterface

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - WIDTH-bit, STAGES-deep flop synchroniser with async active-low reset
module pin_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rpi_bus_bridge.sv
// rtl/rpi_bus_bridge.sv - RPi parallel bus to wishbone bridge, one wb cycle per pin_clk rise
// Optional pin_clk glitch filter: define RPI_BRIDGE_GLITCH_FILTER_EN.
module rpi_bus_bridge
    import rpi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            ref_clk,
    input  logic            reset_n,
    rpi_bus_bridge_if.slave bus,
    output logic            timeout
);

    localparam int SYNC_W = 3 + BUS_AW + BUS_DW;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic              clk_s, cs_s, we_s;
    logic [BUS_AW-1:0] addr_s;
    logic [BUS_DW-1:0] data_s;
    logic              clk_rise;

    pin_sync #(
        .WIDTH  (SYNC_W),
        .STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk   (ref_clk),
        .rst_n (reset_n),
        .d_i   ({bus.pin_clk, bus.pin_cs, bus.pin_we, bus.pin_addr, bus.pin_data_in}),
        .q_o   ({clk_s, cs_s, we_s, addr_s, data_s})
    );

`ifdef RPI_BRIDGE_GLITCH_FILTER_EN
    // Rise only after three low samples followed by three high samples.
    logic [4:0] clk_hist_q;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) clk_hist_q <= '0;
        else          clk_hist_q <= {clk_hist_q[3:0], clk_s};
    end

    assign clk_rise = clk_s & clk_hist_q[0] & clk_hist_q[1]
                    & ~clk_hist_q[2] & ~clk_hist_q[3] & ~clk_hist_q[4];
`else
    logic clk_d_q;

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) clk_d_q <= 1'b0;
        else          clk_d_q <= clk_s;
    end

    assign clk_rise = clk_s & ~clk_d_q;
`endif

    bridge_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb_q, we_q, ack_q, timeout_q;
    logic [BUS_AW-1:0] addr_q;
    logic [BUS_DW-1:0] wdata_q, rdata_q;

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clk_rise && cs_s) begin
                        addr_q  <= addr_s;
                        we_q    <= we_s;
                        wdata_q <= data_s;
                        stb_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    // Ack has priority over an expiring counter; a dropped cs skips HOLD.
                    if (bus.wb_ack) begin
                        stb_q   <= 1'b0;
                        ack_q   <= cs_s;
                        state_q <= cs_s ? HOLD : IDLE;
                        if (!we_q) rdata_q <= bus.wb_data_in;
                    end else if (cnt_d >= CNT_LIMIT) begin
                        stb_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        rdata_q   <= TIMEOUT_DATA;
                        ack_q     <= cs_s;
                        state_q   <= cs_s ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!cs_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wb_addr      = addr_q;
    assign bus.wb_data_out  = wdata_q;
    assign bus.wb_we        = we_q;
    assign bus.wb_stb       = stb_q;
    assign bus.wb_cyc       = stb_q;
    assign bus.pin_data_out = rdata_q;
    assign bus.pin_ack      = ack_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_rpi_bus_bridge.sv
// tb/tb_rpi_bus_bridge.sv - directed table-driven bench for rpi_bus_bridge
module tb_rpi_bus_bridge;
    import rpi_bridge_pkg::*;

`ifdef RPI_BRIDGE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic ref_clk = 1'b0;
    logic reset_n = 1'b0;
    logic timeout;

    rpi_bus_bridge_if bus ();

    rpi_bus_bridge #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .ref_clk (ref_clk),
        .reset_n (reset_n),
        .bus     (bus),
        .timeout (timeout)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         ack_dly;
        logic [7:0] exp_pdo;
    } vec_t;

    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_stb(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.wb_stb && lat < 30);
    endtask

    task automatic start_txn(input logic we, input logic [1:0] addr, input logic [7:0] wdata);
        bus.pin_cs      = 1'b1;
        bus.pin_we      = we;
        bus.pin_addr    = addr;
        bus.pin_data_in = wdata;
        repeat (3) tick();
        bus.pin_clk = 1'b1;
    endtask

    task automatic release_bus(input string tag, input logic [7:0] exp_pdo);
        int n;
        bus.pin_cs  = 1'b0;
        bus.pin_clk = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.pin_ack && n < 20);
        check({tag, ".ack_low"}, 32'(bus.pin_ack), 0);
        check({tag, ".pdo_kept"}, 32'(bus.pin_data_out), 32'(exp_pdo));
        repeat (6) tick();
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        start_txn(v.we, v.addr, v.wdata);
        wait_stb(lat);
        check({tag, ".lat"}, 32'(lat), 32'(LAT));
        check({tag, ".cyc"}, 32'(bus.wb_cyc), 1);
        check({tag, ".we"}, 32'(bus.wb_we), 32'(v.we));
        check({tag, ".addr"}, 32'(bus.wb_addr), 32'(v.addr));
        check({tag, ".wdata"}, 32'(bus.wb_data_out), 32'(v.wdata));
        bus.wb_data_in = v.rdata;
        repeat (v.ack_dly) tick();
        check({tag, ".stb_held"}, 32'(bus.wb_stb), 1);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        check({tag, ".stb_drop"}, 32'(bus.wb_stb), 0);
        check({tag, ".pin_ack"}, 32'(bus.pin_ack), 1);
        check({tag, ".pdo"}, 32'(bus.pin_data_out), 32'(v.exp_pdo));
        check({tag, ".no_to"}, 32'(timeout), 0);
        repeat (3) tick();
        check({tag, ".ack_hold"}, 32'(bus.pin_ack), 1);
        release_bus(tag, v.exp_pdo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int seen;

        vecs[0] = '{1'b1, 2'b01, 8'h41, 8'h00, 2, 8'h00};
        vecs[1] = '{1'b0, 2'b10, 8'h00, 8'h5A, 1, 8'h5A};
        vecs[2] = '{1'b1, 2'b11, 8'hC3, 8'h00, 0, 8'h5A};
        vecs[3] = '{1'b0, 2'b00, 8'h00, 8'hA5, 3, 8'hA5};
        vecs[4] = '{1'b0, 2'b01, 8'h00, 8'h00, 0, 8'h00};
        vecs[5] = '{1'b1, 2'b10, 8'h99, 8'h00, 1, 8'hFF};
        vecs[6] = '{1'b0, 2'b11, 8'h00, 8'h3C, 2, 8'h3C};

        bus.pin_clk     = 1'b0;
        bus.pin_cs      = 1'b0;
        bus.pin_we      = 1'b0;
        bus.pin_addr    = '0;
        bus.pin_data_in = '0;
        bus.wb_data_in  = '0;
        bus.wb_ack      = 1'b0;
        repeat (3) tick();
        check("rst.stb", 32'(bus.wb_stb), 0);
        check("rst.cyc", 32'(bus.wb_cyc), 0);
        check("rst.pin_ack", 32'(bus.pin_ack), 0);
        check("rst.pdo", 32'(bus.pin_data_out), 0);
        check("rst.timeout", 32'(timeout), 0);
        check("rst.wb_regs", 32'({bus.wb_we, bus.wb_addr, bus.wb_data_out}), 0);
        reset_n = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Slave never acks: strobe must last exactly 255 cycles.
        start_txn(1'b0, 2'b10, 8'h00);
        wait_stb(lat);
        check("to.lat", 32'(lat), 32'(LAT));
        n = 1;
        seen = 0;
        while (n < 400) begin
            tick();
            if (timeout) seen++;
            if (!bus.wb_stb) break;
            n++;
        end
        check("to.stb_cycles", 32'(n), 255);
        check("to.pulse", 32'(timeout), 1);
        check("to.pulse_early", 32'(seen), 1);
        check("to.pdo", 32'(bus.pin_data_out), 32'h0FF);
        check("to.pin_ack", 32'(bus.pin_ack), 1);
        tick();
        check("to.pulse_one", 32'(timeout), 0);
        release_bus("to", 8'hFF);

        // cs dropped two cycles into REQ, ack five cycles in.
        start_txn(1'b1, 2'b00, 8'h11);
        wait_stb(lat);
        check("csd.lat", 32'(lat), 32'(LAT));
        repeat (2) tick();
        bus.pin_cs  = 1'b0;
        bus.pin_clk = 1'b0;
        repeat (3) tick();
        check("csd.stb_held", 32'(bus.wb_stb), 1);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        check("csd.stb_drop", 32'(bus.wb_stb), 0);
        check("csd.state", 32'(dut.state_q), 32'(IDLE));
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.pin_ack) seen++;
        end
        check("csd.pin_ack", 32'(seen), 0);
        run_txn(vecs[5], "csd.next");

        // Reset mid-request clears outputs without waiting for a clock edge.
        start_txn(1'b1, 2'b01, 8'h22);
        wait_stb(lat);
        check("rmid.lat", 32'(lat), 32'(LAT));
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid.stb", 32'(bus.wb_stb), 0);
        check("rmid.pin_ack", 32'(bus.pin_ack), 0);
        check("rmid.pdo", 32'(bus.pin_data_out), 0);
        bus.pin_cs  = 1'b0;
        bus.pin_clk = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.wb_stb) seen++;
        end
        check("rmid.no_txn", 32'(seen), 0);
        run_txn(vecs[6], "rmid.next");

`ifdef RPI_BRIDGE_GLITCH_FILTER_EN
        // Two-cycle pin_clk pulse is filtered out; four-cycle pulse is accepted.
        bus.pin_cs      = 1'b1;
        bus.pin_we      = 1'b1;
        bus.pin_addr    = 2'b10;
        bus.pin_data_in = 8'h6E;
        repeat (3) tick();
        bus.pin_clk = 1'b1;
        repeat (2) tick();
        bus.pin_clk = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.wb_stb) seen++;
        end
        check("glitch.short", 32'(seen), 0);
        bus.pin_clk = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 4) bus.pin_clk = 1'b0;
        end while (!bus.wb_stb && lat < 30);
        check("glitch.lat", 32'(lat), 5);
        check("glitch.wdata", 32'(bus.wb_data_out), 32'h06E);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        check("glitch.pin_ack", 32'(bus.pin_ack), 1);
        release_bus("glitch", 8'h3C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
